// File: rtl/mem_rd_arb_ctrl_if.sv
// AXI4 read-master bundle used by mem_rd_arb_ctrl.
// The master modport is the controller side; the slave modport is the memory side.
interface mem_rd_arb_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 512,
    parameter int ID_W   = 4
) ();
    logic [ID_W-1:0]   M_AXI_ARID;
    logic [ADDR_W-1:0] M_AXI_ARADDR;
    logic [7:0]        M_AXI_ARLEN;
    logic [2:0]        M_AXI_ARSIZE;
    logic [1:0]        M_AXI_ARBURST;
    logic              M_AXI_ARLOCK;
    logic [3:0]        M_AXI_ARCACHE;
    logic [2:0]        M_AXI_ARPROT;
    logic [3:0]        M_AXI_ARQOS;
    logic              M_AXI_ARVALID;
    logic              M_AXI_ARREADY;
    logic [ID_W-1:0]   M_AXI_RID;
    logic [DATA_W-1:0] M_AXI_RDATA;
    logic [1:0]        M_AXI_RRESP;
    logic              M_AXI_RLAST;
    logic              M_AXI_RVALID;
    logic              M_AXI_RREADY;

    modport master (
        output M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST,
               M_AXI_ARLOCK, M_AXI_ARCACHE, M_AXI_ARPROT, M_AXI_ARQOS, M_AXI_ARVALID,
               M_AXI_RREADY,
        input  M_AXI_ARREADY, M_AXI_RID, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST,
               M_AXI_RVALID
    );

    modport slave (
        input  M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST,
               M_AXI_ARLOCK, M_AXI_ARCACHE, M_AXI_ARPROT, M_AXI_ARQOS, M_AXI_ARVALID,
               M_AXI_RREADY,
        output M_AXI_ARREADY, M_AXI_RID, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST,
               M_AXI_RVALID
    );
endinterface

// File: rtl/mem_rd_arb_ctrl.sv
// Multi-port read arbiter in front of one AXI4 read master.
// Round-robin grants one requestor at a time onto the AR channel, limits each
// port to MAX_OUTS bursts in flight, and steers R beats back by RID.
// Optional macro MEM_RD_RRESP_CHK_EN: sticky per-port error on RRESP != OKAY.
module mem_rd_arb_ctrl #(
    parameter int NPORT    = 10,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 512,
    parameter int ID_W     = 4,
    parameter int MAX_OUTS = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NPORT-1:0]        REQ,
    input  logic [NPORT*8-1:0]      LEN,
    input  logic [NPORT*ADDR_W-1:0] ADR,
    output logic [NPORT-1:0]        ACK,
    output logic [NPORT-1:0]        WREN,
    output logic [NPORT-1:0]        WEND,
    output logic [DATA_W-1:0]       WDAT,
    output logic [NPORT-1:0]        ERR,
    mem_rd_arb_ctrl_if.master       m_axi
);
    localparam int         PW         = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam logic [3:0] MAX_OUTS_C = 4'(MAX_OUTS);
    localparam logic [2:0] AR_SIZE    = 3'($clog2(DATA_W / 8));

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT_RDY = 2'd2} state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       gnt_q, gnt_d, rr_q, rr_d;
    logic [7:0]          len_q, len_d, arlen_q, arlen_d;
    logic [ADDR_W-1:0]   adr_q, adr_d, araddr_q, araddr_d;
    logic [ID_W-1:0]     arid_q, arid_d;
    logic                arvalid_q, arvalid_d;
    logic [NPORT-1:0]    ack_q, ack_d, wren_q, wren_d, wend_q, wend_d;
    logic [DATA_W-1:0]   wdat_q, wdat_d;
    logic [3:0]          cnt_q [NPORT];
    logic [3:0]          cnt_d [NPORT];
    logic [NPORT-1:0]    elig, inc_v, dec_v;
    logic                pick_vld;
    logic [PW-1:0]       pick;
    logic [7:0]          len_sel;
    logic [ADDR_W-1:0]   adr_sel;

    // Eligible set and round-robin pick starting at the pointer, plus its LEN/ADR
    always_comb begin : arb_comb
        int s;
        s        = 0;
        elig     = '0;
        pick_vld = 1'b0;
        pick     = '0;
        len_sel  = '0;
        adr_sel  = '0;
        for (int p = 0; p < NPORT; p++) begin
            elig[p] = REQ[p] && (cnt_q[p] < MAX_OUTS_C);
        end
        for (int i = 0; i < NPORT; i++) begin
            s = int'(rr_q) + i;
            if (s >= NPORT) s = s - NPORT;
            if (!pick_vld && elig[PW'(s)]) begin
                pick_vld = 1'b1;
                pick     = PW'(s);
            end
        end
        for (int p = 0; p < NPORT; p++) begin
            if (pick == PW'(p)) begin
                len_sel = LEN[p*8 +: 8];
                adr_sel = ADR[p*ADDR_W +: ADDR_W];
            end
        end
    end

    // Command FSM: grant in IDLE, load AR fields in ISSUE, hold them until ARREADY
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        rr_d      = rr_q;
        len_d     = len_q;
        adr_d     = adr_q;
        arid_d    = arid_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        arvalid_d = arvalid_q;
        ack_d     = '0;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    gnt_d   = pick;
                    rr_d    = (pick == PW'(NPORT - 1)) ? '0 : pick + PW'(1);
                    len_d   = len_sel;
                    adr_d   = adr_sel;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                araddr_d  = adr_q;
                arlen_d   = len_q - 8'd1;    // LEN=0 wraps to 255 (256 beats)
                arid_d    = ID_W'(gnt_q);
                arvalid_d = 1'b1;
                for (int p = 0; p < NPORT; p++) begin
                    ack_d[p] = (gnt_q == PW'(p));
                end
                state_d   = WAIT_RDY;
            end
            WAIT_RDY: begin
                if (m_axi.M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                arvalid_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    // Outstanding-burst counters: +1 on AR handshake, -1 on last beat, floor at 0
    always_comb begin
        inc_v = '0;
        dec_v = '0;
        for (int p = 0; p < NPORT; p++) begin
            inc_v[p] = arvalid_q && m_axi.M_AXI_ARREADY && (arid_q == ID_W'(p));
            dec_v[p] = m_axi.M_AXI_RVALID && m_axi.M_AXI_RLAST && (m_axi.M_AXI_RID == ID_W'(p));
            cnt_d[p] = cnt_q[p];
            if (inc_v[p] && !dec_v[p]) begin
                cnt_d[p] = cnt_q[p] + 4'd1;
            end else if (dec_v[p] && !inc_v[p] && (cnt_q[p] != 4'd0)) begin
                cnt_d[p] = cnt_q[p] - 4'd1;
            end
        end
    end

    // Read-data steering by RID; out-of-range IDs match no port and are dropped
    always_comb begin
        wren_d = '0;
        wend_d = '0;
        wdat_d = m_axi.M_AXI_RDATA;
        for (int p = 0; p < NPORT; p++) begin
            wren_d[p] = m_axi.M_AXI_RVALID && (m_axi.M_AXI_RID == ID_W'(p));
            wend_d[p] = wren_d[p] && m_axi.M_AXI_RLAST;
        end
    end

    // State, command and read-path registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            rr_q      <= '0;
            len_q     <= '0;
            adr_q     <= '0;
            arid_q    <= '0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arvalid_q <= 1'b0;
            ack_q     <= '0;
            wren_q    <= '0;
            wend_q    <= '0;
            wdat_q    <= '0;
            for (int p = 0; p < NPORT; p++) cnt_q[p] <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            rr_q      <= rr_d;
            len_q     <= len_d;
            adr_q     <= adr_d;
            arid_q    <= arid_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            arvalid_q <= arvalid_d;
            ack_q     <= ack_d;
            wren_q    <= wren_d;
            wend_q    <= wend_d;
            wdat_q    <= wdat_d;
            for (int p = 0; p < NPORT; p++) cnt_q[p] <= cnt_d[p];
        end
    end

`ifdef MEM_RD_RRESP_CHK_EN
    logic [NPORT-1:0] err_q, err_d;

    // Sticky error flag per port on any non-OKAY response beat
    always_comb begin
        err_d = err_q;
        for (int p = 0; p < NPORT; p++) begin
            if (m_axi.M_AXI_RVALID && (m_axi.M_AXI_RID == ID_W'(p)) &&
                (m_axi.M_AXI_RRESP != 2'b00)) begin
                err_d[p] = 1'b1;
            end
        end
    end

    // Error flags clear only on reset
    always_ff @(posedge CLK) begin
        if (RST) err_q <= '0;
        else     err_q <= err_d;
    end

    assign ERR = err_q;
`else
    logic unused_rresp;
    assign unused_rresp = ^m_axi.M_AXI_RRESP;
    assign ERR          = '0;
`endif

    assign ACK  = ack_q;
    assign WREN = wren_q;
    assign WEND = wend_q;
    assign WDAT = wdat_q;

    assign m_axi.M_AXI_ARID    = arid_q;
    assign m_axi.M_AXI_ARADDR  = araddr_q;
    assign m_axi.M_AXI_ARLEN   = arlen_q;
    assign m_axi.M_AXI_ARSIZE  = AR_SIZE;
    assign m_axi.M_AXI_ARBURST = 2'b01;
    assign m_axi.M_AXI_ARLOCK  = 1'b0;
    assign m_axi.M_AXI_ARCACHE = 4'd0;
    assign m_axi.M_AXI_ARPROT  = 3'd0;
    assign m_axi.M_AXI_ARQOS   = 4'd0;
    assign m_axi.M_AXI_ARVALID = arvalid_q;
    assign m_axi.M_AXI_RREADY  = 1'b1;
endmodule

// File: tb/tb_mem_rd_arb_ctrl.sv
// Directed testbench for mem_rd_arb_ctrl (default parameters).
// Build with +define+MEM_RD_RRESP_CHK_EN to exercise the error flags.
module tb_mem_rd_arb_ctrl;
    localparam int NPORT  = 10;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 512;
    localparam int ID_W   = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NPORT-1:0]        req;
    logic [NPORT*8-1:0]      len;
    logic [NPORT*ADDR_W-1:0] adr;
    logic [NPORT-1:0]        ack, wren, wend, err;
    logic [DATA_W-1:0]       wdat;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    mem_rd_arb_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) axi ();

    mem_rd_arb_ctrl #(.NPORT(NPORT), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W),
                      .MAX_OUTS(4)) dut (
        .CLK(clk), .RST(rst), .REQ(req), .LEN(len), .ADR(adr),
        .ACK(ack), .WREN(wren), .WEND(wend), .WDAT(wdat), .ERR(err),
        .m_axi(axi.master)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        axi.M_AXI_ARREADY = 1'b1;
        axi.M_AXI_RVALID  = 1'b0;
        axi.M_AXI_RLAST   = 1'b0;
        axi.M_AXI_RID     = '0;
        axi.M_AXI_RDATA   = '0;
        axi.M_AXI_RRESP   = 2'b00;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Advance until an ACK pulse appears or the cycle budget runs out (returns 0).
    task automatic wait_ack(output logic [NPORT-1:0] a);
        int n;
        n = 0;
        a = '0;
        while (a == '0 && n < 20) begin
            tick();
            a = ack;
            n++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        chk_cnt++; if (axi.M_AXI_ARVALID !== 1'b0) $display("FAIL rst_arvalid got %0b want 0", axi.M_AXI_ARVALID); else pass_cnt++;
        chk_cnt++; if ({ack, wren, wend, err} !== '0) $display("FAIL rst_strobes got %h want 0", {ack, wren, wend, err}); else pass_cnt++;
        chk_cnt++; if (wdat !== '0) $display("FAIL rst_wdat got nonzero want 0"); else pass_cnt++;
        chk_cnt++; if ({axi.M_AXI_ARID, axi.M_AXI_ARLEN, axi.M_AXI_ARADDR} !== '0)
            $display("FAIL rst_ar_fields got %h want 0", {axi.M_AXI_ARID, axi.M_AXI_ARLEN, axi.M_AXI_ARADDR}); else pass_cnt++;
        chk_cnt++; if (axi.M_AXI_RREADY !== 1'b1) $display("FAIL rready got %0b want 1", axi.M_AXI_RREADY); else pass_cnt++;
    endtask

    task automatic test_single_issue();
        do_reset();
        len[3*8 +: 8]           = 8'd16;
        adr[3*ADDR_W +: ADDR_W] = 32'h0000_1000;
        req[3] = 1'b1;
        tick();
        chk_cnt++; if (ack !== '0) $display("FAIL single_ack_early got %h want 0", ack); else pass_cnt++;
        tick();
        chk_cnt++; if (ack !== 10'h008) $display("FAIL single_ack got %h want 008", ack); else pass_cnt++;
        chk_cnt++; if ({axi.M_AXI_ARVALID, axi.M_AXI_ARID, axi.M_AXI_ARLEN, axi.M_AXI_ARADDR} !== {1'b1, 4'd3, 8'd15, 32'h0000_1000})
            $display("FAIL single_ar got v=%0b id=%0d len=%0d addr=%h want v=1 id=3 len=15 addr=00001000",
                     axi.M_AXI_ARVALID, axi.M_AXI_ARID, axi.M_AXI_ARLEN, axi.M_AXI_ARADDR); else pass_cnt++;
        chk_cnt++; if ({axi.M_AXI_ARSIZE, axi.M_AXI_ARBURST, axi.M_AXI_ARLOCK, axi.M_AXI_ARCACHE, axi.M_AXI_ARPROT, axi.M_AXI_ARQOS}
                       !== {3'd6, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0})
            $display("FAIL fixed_ar got size=%0d burst=%0d want size=6 burst=1", axi.M_AXI_ARSIZE, axi.M_AXI_ARBURST); else pass_cnt++;
        req[3] = 1'b0;
        tick();
        chk_cnt++; if ({ack, axi.M_AXI_ARVALID} !== '0) $display("FAIL single_done got ack=%h v=%0b want 0 0", ack, axi.M_AXI_ARVALID); else pass_cnt++;
    endtask

    task automatic test_round_robin();
        logic [NPORT-1:0] a;
        logic [NPORT-1:0] exp_a;
        do_reset();
        req = '1;
        for (int g = 0; g <= NPORT; g++) begin
            wait_ack(a);
            exp_a = '0;
            exp_a[g % NPORT] = 1'b1;
            chk_cnt++; if (a !== exp_a) $display("FAIL rr_grant%0d got %h want %h", g, a, exp_a); else pass_cnt++;
            chk_cnt++; if (axi.M_AXI_ARID !== 4'(g % NPORT)) $display("FAIL rr_arid%0d got %0d want %0d", g, axi.M_AXI_ARID, g % NPORT); else pass_cnt++;
        end
        req = '0;
        tick();
    endtask

    task automatic test_max_outs();
        logic [NPORT-1:0] a;
        logic [NPORT-1:0] seen;
        do_reset();
        req[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_ack(a);
            chk_cnt++; if (a !== 10'h001) $display("FAIL outs_grant%0d got %h want 001", k, a); else pass_cnt++;
        end
        seen = '0;
        for (int k = 0; k < 12; k++) begin
            tick();
            seen = seen | ack;
        end
        chk_cnt++; if (seen !== '0) $display("FAIL outs_masked got %h want 000", seen); else pass_cnt++;
        req[1] = 1'b1;
        wait_ack(a);
        chk_cnt++; if (a !== 10'h002) $display("FAIL outs_port1 got %h want 002", a); else pass_cnt++;
        req[1] = 1'b0;
        axi.M_AXI_RVALID = 1'b1;
        axi.M_AXI_RLAST  = 1'b1;
        axi.M_AXI_RID    = 4'd0;
        tick();
        axi.M_AXI_RVALID = 1'b0;
        axi.M_AXI_RLAST  = 1'b0;
        wait_ack(a);
        chk_cnt++; if (a !== 10'h001) $display("FAIL outs_reopen got %h want 001", a); else pass_cnt++;
        req = '0;
        tick();
    endtask

    task automatic test_len0_stall();
        logic [NPORT-1:0] a;
        do_reset();
        axi.M_AXI_ARREADY = 1'b0;
        len[5*8 +: 8]           = 8'd0;
        adr[5*ADDR_W +: ADDR_W] = 32'hDEAD_BEE0;
        req[5] = 1'b1;
        wait_ack(a);
        chk_cnt++; if (a !== 10'h020) $display("FAIL stall_ack got %h want 020", a); else pass_cnt++;
        req[5] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk_cnt++; if ({axi.M_AXI_ARVALID, axi.M_AXI_ARID, axi.M_AXI_ARLEN, axi.M_AXI_ARADDR} !== {1'b1, 4'd5, 8'd255, 32'hDEAD_BEE0})
                $display("FAIL stall_hold%0d got v=%0b id=%0d len=%0d addr=%h want v=1 id=5 len=255 addr=deadbee0",
                         k, axi.M_AXI_ARVALID, axi.M_AXI_ARID, axi.M_AXI_ARLEN, axi.M_AXI_ARADDR); else pass_cnt++;
            tick();
            chk_cnt++; if (ack !== '0) $display("FAIL stall_ack_pulse%0d got %h want 000", k, ack); else pass_cnt++;
        end
        axi.M_AXI_ARREADY = 1'b1;
        tick();
        chk_cnt++; if (axi.M_AXI_ARVALID !== 1'b0) $display("FAIL stall_clear got %0b want 0", axi.M_AXI_ARVALID); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [NPORT-1:0] a;
        do_reset();
        axi.M_AXI_ARREADY = 1'b0;
        req[4] = 1'b1;
        wait_ack(a);
        chk_cnt++; if (a !== 10'h010) $display("FAIL midrst_ack got %h want 010", a); else pass_cnt++;
        req[4] = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_cnt++; if ({axi.M_AXI_ARVALID, ack} !== '0) $display("FAIL midrst_drop got v=%0b ack=%h want 0 000", axi.M_AXI_ARVALID, ack); else pass_cnt++;
        axi.M_AXI_RVALID = 1'b1;
        axi.M_AXI_RLAST  = 1'b1;
        axi.M_AXI_RID    = 4'd4;
        tick();
        axi.M_AXI_RVALID = 1'b0;
        axi.M_AXI_RLAST  = 1'b0;
        chk_cnt++; if ({wren, wend} !== {10'h010, 10'h010}) $display("FAIL midrst_fwd got wren=%h wend=%h want 010 010", wren, wend); else pass_cnt++;
        axi.M_AXI_ARREADY = 1'b1;
    endtask

    task automatic test_rdata();
        logic [DATA_W-1:0] pat;
        do_reset();
        pat = {(DATA_W/8){8'hA5}};
        axi.M_AXI_RVALID = 1'b1;
        axi.M_AXI_RLAST  = 1'b1;
        axi.M_AXI_RID    = 4'd7;
        axi.M_AXI_RDATA  = pat;
        chk_cnt++; if (wren !== '0) $display("FAIL rd_latency got %h want 000", wren); else pass_cnt++;
        tick();
        chk_cnt++; if ({wren, wend} !== {10'h080, 10'h080}) $display("FAIL rd_id7 got wren=%h wend=%h want 080 080", wren, wend); else pass_cnt++;
        chk_cnt++; if (wdat !== pat) $display("FAIL rd_wdat got %h want a5 pattern", wdat[31:0]); else pass_cnt++;
        axi.M_AXI_RID   = 4'd2;
        axi.M_AXI_RLAST = 1'b0;
        tick();
        chk_cnt++; if ({wren, wend} !== {10'h004, 10'h000}) $display("FAIL rd_id2_mid got wren=%h wend=%h want 004 000", wren, wend); else pass_cnt++;
        axi.M_AXI_RID   = 4'd12;
        axi.M_AXI_RLAST = 1'b1;
        tick();
        chk_cnt++; if ({wren, wend} !== '0) $display("FAIL rd_id12_drop got wren=%h wend=%h want 000 000", wren, wend); else pass_cnt++;
        axi.M_AXI_RVALID = 1'b0;
        tick();
        chk_cnt++; if (wren !== '0) $display("FAIL rd_idle got %h want 000", wren); else pass_cnt++;
    endtask

    task automatic test_err();
        do_reset();
        axi.M_AXI_RVALID = 1'b1;
        axi.M_AXI_RID    = 4'd2;
        axi.M_AXI_RRESP  = 2'b10;
        tick();
        axi.M_AXI_RVALID = 1'b0;
        axi.M_AXI_RRESP  = 2'b00;
        repeat (3) tick();
`ifdef MEM_RD_RRESP_CHK_EN
        chk_cnt++; if (err !== 10'h004) $display("FAIL err_sticky got %h want 004", err); else pass_cnt++;
        do_reset();
        chk_cnt++; if (err !== '0) $display("FAIL err_clear got %h want 000", err); else pass_cnt++;
`else
        chk_cnt++; if (err !== '0) $display("FAIL err_disabled got %h want 000", err); else pass_cnt++;
`endif
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        len = '0;
        adr = '0;
        test_reset();
        test_single_issue();
        test_round_robin();
        test_max_outs();
        test_len0_stall();
        test_reset_mid();
        test_rdata();
        test_err();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
